// File: rtl/mips_pkg.sv
// Encodings shared by control, decode and writeback: load sizes and wb_bus bit positions.
package mips_pkg;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the byte/halfword/word addressed by a load from the raw memory word.
module load_formatter
  import mips_pkg::*;
#(
  parameter int unsigned len = 32
) (
  input  logic [len-1:0] mem_data,
  input  logic [1:0]     load_size,
  input  logic           load_unsigned,
  input  logic [1:0]     byte_offset,
  output logic [len-1:0] formatted
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_data[7:0];
    case (byte_offset)
      2'd0:    byte_sel = mem_data[7:0];
      2'd1:    byte_sel = mem_data[15:8];
      2'd2:    byte_sel = mem_data[23:16];
      default: byte_sel = mem_data[31:24];
    endcase
    // Misaligned halfwords are not trapped; the low offset bit is simply dropped.
    half_sel = byte_offset[1] ? mem_data[31:16] : mem_data[15:0];
  end

  always_comb begin
    formatted = mem_data;
    case (load_size)
      LOAD_BYTE: formatted = {{(len-8){~load_unsigned & byte_sel[7]}}, byte_sel};
      LOAD_HALF: formatted = {{(len-16){~load_unsigned & half_sel[15]}}, half_sel};
      default:   formatted = mem_data;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// MEM/WB stage register, register-file write port, retired-instruction counter and sticky halt.
module writeback
  import mips_pkg::*;
#(
  parameter int unsigned len = 32,
  parameter int unsigned NB  = $clog2(len)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic           in_enable,
  input  logic           in_flush,
  input  logic [len-1:0] in_alu_result,
  input  logic [len-1:0] in_mem_data,
  input  logic [NB-1:0]  in_write_register,
  input  logic [1:0]     in_writeBack_bus,
  input  logic [1:0]     in_load_size,
  input  logic           in_load_unsigned,
  input  logic [1:0]     in_byte_offset,
  input  logic           in_halt,
  output logic           RegWrite,
  output logic [len-1:0] write_data,
  output logic [NB-1:0]  write_register,
  output logic           out_halt,
  output logic [len-1:0] out_retired
);

  localparam logic [len-1:0] ONE = {{(len-1){1'b0}}, 1'b1};

  logic           valid_q;
  logic [len-1:0] alu_q;
  logic [len-1:0] mem_q;
  logic [NB-1:0]  wreg_q;
  logic [1:0]     wb_q;
  logic [1:0]     size_q;
  logic           unsigned_q;
  logic [1:0]     offset_q;
  logic           halt_fld_q;
  logic           halted_q;
  logic [len-1:0] retired_q;
  logic [len-1:0] formatted;

  always_ff @(posedge clk) begin
    if (reset || halted_q || in_flush) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      mem_q      <= '0;
      wreg_q     <= '0;
      wb_q       <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      offset_q   <= '0;
      halt_fld_q <= 1'b0;
    end else if (in_enable) begin
      valid_q    <= in_valid;
      alu_q      <= in_alu_result;
      mem_q      <= in_mem_data;
      wreg_q     <= in_write_register;
      wb_q       <= in_writeBack_bus;
      size_q     <= in_load_size;
      unsigned_q <= in_load_unsigned;
      offset_q   <= in_byte_offset;
      halt_fld_q <= in_halt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else if (valid_q && halt_fld_q) begin
      halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (in_valid && in_enable && !in_flush && !halted_q) begin
      retired_q <= retired_q + ONE;
    end
  end

  load_formatter #(
    .len(len)
  ) u_load_formatter (
    .mem_data     (mem_q),
    .load_size    (size_q),
    .load_unsigned(unsigned_q),
    .byte_offset  (offset_q),
    .formatted    (formatted)
  );

  always_comb begin
    RegWrite       = valid_q & wb_q[WB_REGWRITE] & (wreg_q != '0);
    write_data     = '0;
    write_register = '0;
    if (valid_q) begin
      write_data     = wb_q[WB_MEMTOREG] ? formatted : alu_q;
      write_register = wreg_q;
    end
  end

  assign out_halt    = halted_q;
  assign out_retired = retired_q;

endmodule

// File: tb/tb_writeback.sv
// Directed and randomized checks of the writeback stage against a behavioural reference model.
module tb_writeback;

  localparam int unsigned LEN = 32;
  localparam int unsigned NBW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_enable, in_flush;
  logic [LEN-1:0] in_alu_result, in_mem_data;
  logic [NBW-1:0] in_write_register;
  logic [1:0]     in_writeBack_bus, in_load_size, in_byte_offset;
  logic           in_load_unsigned, in_halt;
  logic           RegWrite;
  logic [LEN-1:0] write_data;
  logic [NBW-1:0] write_register;
  logic           out_halt;
  logic [LEN-1:0] out_retired;

  int total = 0;
  int bad   = 0;

  // Reference model: the instruction currently sitting in WB, plus halt and count.
  logic           m_valid, m_uns, m_halt, m_halted;
  logic [LEN-1:0] m_alu, m_mem, m_count;
  logic [NBW-1:0] m_wreg;
  logic [1:0]     m_wb, m_size, m_off;

  writeback #(
    .len(LEN),
    .NB (NBW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_enable        (in_enable),
    .in_flush         (in_flush),
    .in_alu_result    (in_alu_result),
    .in_mem_data      (in_mem_data),
    .in_write_register(in_write_register),
    .in_writeBack_bus (in_writeBack_bus),
    .in_load_size     (in_load_size),
    .in_load_unsigned (in_load_unsigned),
    .in_byte_offset   (in_byte_offset),
    .in_halt          (in_halt),
    .RegWrite         (RegWrite),
    .write_data       (write_data),
    .write_register   (write_register),
    .out_halt         (out_halt),
    .out_retired      (out_retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] sz, logic u,
                                           logic [1:0] off);
    longint v;
    if (sz == 2'b00) begin
      v = longint'((w >> (8 * off)) & 32'hFF);
      if (!u && v > 127) v = v - 256;
    end else if (sz == 2'b01) begin
      v = longint'((w >> (off[1] ? 16 : 0)) & 32'hFFFF);
      if (!u && v > 32767) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [LEN-1:0] obs, input logic [LEN-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic was_halted;
    if (reset) begin
      {m_valid, m_uns, m_halt, m_halted} = '0;
      {m_alu, m_mem, m_count} = '0;
      {m_wreg, m_wb, m_size, m_off} = '0;
    end else begin
      was_halted = m_halted;
      if (m_valid && m_halt) m_halted = 1'b1;
      if (was_halted || in_flush) begin
        {m_valid, m_uns, m_halt} = '0;
        {m_alu, m_mem} = '0;
        {m_wreg, m_wb, m_size, m_off} = '0;
      end else if (in_enable) begin
        m_valid = in_valid;
        m_alu   = in_alu_result;
        m_mem   = in_mem_data;
        m_wreg  = in_write_register;
        m_wb    = in_writeBack_bus;
        m_size  = in_load_size;
        m_uns   = in_load_unsigned;
        m_off   = in_byte_offset;
        m_halt  = in_halt;
        if (in_valid) m_count = m_count + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [LEN-1:0] e_wd;
    logic           e_rw;
    e_rw = m_valid && m_wb[1] && (m_wreg != 0);
    e_wd = !m_valid ? '0 : (m_wb[0] ? ref_load(m_mem, m_size, m_uns, m_off) : m_alu);
    chk({tag, ".RegWrite"}, LEN'(RegWrite), LEN'(e_rw));
    chk({tag, ".write_data"}, write_data, e_wd);
    chk({tag, ".write_register"}, LEN'(write_register), m_valid ? LEN'(m_wreg) : '0);
    chk({tag, ".out_halt"}, LEN'(out_halt), LEN'(m_halted));
    chk({tag, ".out_retired"}, out_retired, m_count);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic v, input logic en, input logic fl, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [4:0] wreg, input logic [1:0] wb,
                        input logic [1:0] sz, input logic u, input logic [1:0] off,
                        input logic h);
    in_valid = v; in_enable = en; in_flush = fl;
    in_alu_result = alu; in_mem_data = mem; in_write_register = wreg;
    in_writeBack_bus = wb; in_load_size = sz; in_load_unsigned = u;
    in_byte_offset = off; in_halt = h;
  endtask

  task automatic rand_in();
    set_in(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           $urandom, $urandom, 5'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom_range(0, 29) == 0));
  endtask

  logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01,
                              32'h80FF7F01};
  logic [1:0]  ld_sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
  logic        ld_u   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  ld_off [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd1};

  initial begin
    logic           s_rw;
    logic [LEN-1:0] s_wd, s_ret;
    logic [NBW-1:0] s_wr;

    // Reset with arbitrary inputs.
    reset = 1'b1;
    rand_in();
    step();
    rand_in();
    step();
    chk("reset.RegWrite", LEN'(RegWrite), '0);
    chk("reset.write_data", write_data, '0);
    chk("reset.write_register", LEN'(write_register), '0);
    chk("reset.out_halt", LEN'(out_halt), '0);
    chk("reset.out_retired", out_retired, '0);
    reset = 1'b0;

    // ALU writeback.
    set_in(1, 1, 0, 32'h12345678, $urandom, 5'd5, 2'b10, 2'b00, 0, 2'd0, 0);
    step();
    chk("alu.RegWrite", LEN'(RegWrite), 1);
    chk("alu.write_register", LEN'(write_register), 5);
    chk("alu.write_data", write_data, 32'h12345678);
    chk("alu.out_retired", out_retired, 1);

    // Load formatting.
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 0, $urandom, 32'h80FF7F01, 5'd7, 2'b11, ld_sz[i], ld_u[i], ld_off[i], 0);
      step();
      chk($sformatf("load%0d.write_data", i), write_data, ld_exp[i]);
      chk($sformatf("load%0d.RegWrite", i), LEN'(RegWrite), 1);
    end
    chk("load.out_retired", out_retired, 6);

    // Write to $zero is suppressed but still retires.
    set_in(1, 1, 0, 32'hDEADBEEF, $urandom, 5'd0, 2'b10, 2'b00, 0, 2'd0, 0);
    step();
    chk("zero.RegWrite", LEN'(RegWrite), 0);
    chk("zero.out_retired", out_retired, 7);
    check_model("zero");

    // Stall for three cycles with changing inputs.
    set_in(1, 1, 0, 32'hCAFE0001, $urandom, 5'd9, 2'b10, 2'b00, 0, 2'd0, 0);
    step();
    s_rw = RegWrite; s_wd = write_data; s_wr = write_register; s_ret = out_retired;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      in_enable = 1'b0; in_flush = 1'b0; in_halt = 1'b0;
      step();
      chk("stall.RegWrite", LEN'(RegWrite), LEN'(s_rw));
      chk("stall.write_data", write_data, s_wd);
      chk("stall.write_register", LEN'(write_register), LEN'(s_wr));
      chk("stall.out_retired", out_retired, s_ret);
    end

    // Flush overrides a valid input.
    set_in(1, 0, 1, $urandom, $urandom, 5'd3, 2'b10, 2'b00, 0, 2'd0, 0);
    step();
    chk("flush.RegWrite", LEN'(RegWrite), 0);
    chk("flush.write_data", write_data, 0);
    chk("flush.out_retired", out_retired, s_ret);
    set_in(1, 1, 1, $urandom, $urandom, 5'd3, 2'b10, 2'b00, 0, 2'd0, 0);
    step();
    chk("flush_en.out_retired", out_retired, s_ret);
    check_model("flush_en");

    // HALT reaches WB, then the stage freezes.
    set_in(1, 1, 0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 2'd0, 1);
    step();
    chk("halt.captured", LEN'(out_halt), 0);
    s_ret = out_retired;
    set_in(0, 1, 0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 2'd0, 0);
    step();
    chk("halt.set", LEN'(out_halt), 1);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, $urandom, $urandom, 5'd4, 2'b10, 2'b00, 0, 2'd0, 0);
      step();
      chk("halted.RegWrite", LEN'(RegWrite), 0);
      chk("halted.out_retired", out_retired, s_ret);
      chk("halted.out_halt", LEN'(out_halt), 1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("halt_reset.out_halt", LEN'(out_halt), 0);
    chk("halt_reset.out_retired", out_retired, 0);
    check_model("halt_reset");

    // Randomized traffic with occasional resets, flushes, stalls and halts.
    for (int i = 0; i < 600; i++) begin
      rand_in();
      reset = ($urandom_range(0, 49) == 0);
      step();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
